// File: rtl/core_run_sequencer.sv
// Job sequencer in front of the processor core: launches one program per job,
// measures run length until ack (or TIMEOUT), and returns a result record.
module core_run_sequencer #(
  parameter int unsigned          PC_BITS  = 9,
  parameter int unsigned          CYC_BITS = 16,
  parameter logic [CYC_BITS-1:0]  TIMEOUT  = 16'd50000,
  parameter logic [PC_BITS-1:0]   START0   = 9'd0,
  parameter logic [PC_BITS-1:0]   DONE0    = 9'd144,
  parameter logic [PC_BITS-1:0]   START1   = 9'd145,
  parameter logic [PC_BITS-1:0]   DONE1    = 9'd289,
  parameter logic [PC_BITS-1:0]   START2   = 9'd290,
  parameter logic [PC_BITS-1:0]   DONE2    = 9'd435
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [1:0]          job_prog,
  output logic                req,
  input  logic                ack,
  output logic [PC_BITS-1:0]  start_addr,
  output logic [PC_BITS-1:0]  done_addr,
  output logic                busy,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [1:0]          result_prog,
  output logic [CYC_BITS-1:0] result_cycles,
  output logic                result_timeout,
  output logic                result_error
);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, REPORT} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CYC_BITS-1:0]   r_cnt;
  logic [PC_BITS-1:0]    r_start;
  logic [PC_BITS-1:0]    r_done;
  logic [1:0]            r_res_prog;
  logic [CYC_BITS-1:0]   r_res_cycles;
  logic                  r_res_timeout;
  logic                  r_res_error;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (job_valid) w_next = (job_prog == 2'd3) ? REPORT : LAUNCH;
      end
      LAUNCH: w_next = RUN;
      RUN: begin
        if (ack || (r_cnt == TIMEOUT)) w_next = REPORT;
      end
      REPORT: begin
        if (result_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Addresses are captured at accept so they are already stable when req rises.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt         <= '0;
      r_start       <= '0;
      r_done        <= '0;
      r_res_prog    <= '0;
      r_res_cycles  <= '0;
      r_res_timeout <= 1'b0;
      r_res_error   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (job_valid) begin
            r_res_prog    <= job_prog;
            r_res_cycles  <= '0;
            r_res_timeout <= 1'b0;
            r_res_error   <= (job_prog == 2'd3);
            case (job_prog)
              2'd0: begin r_start <= START0; r_done <= DONE0; end
              2'd1: begin r_start <= START1; r_done <= DONE1; end
              2'd2: begin r_start <= START2; r_done <= DONE2; end
              default: ;
            endcase
          end
        end
        LAUNCH: r_cnt <= CYC_BITS'(1);
        RUN: begin
          if (ack) begin
            r_res_cycles <= r_cnt;
          end else if (r_cnt == TIMEOUT) begin
            r_res_timeout <= 1'b1;
            r_res_cycles  <= TIMEOUT;
          end else begin
            r_cnt <= r_cnt + CYC_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign job_ready      = (r_state == IDLE);
  assign req            = (r_state == LAUNCH);
  assign busy           = (r_state != IDLE);
  assign result_valid   = (r_state == REPORT);
  assign start_addr     = r_start;
  assign done_addr      = r_done;
  assign result_prog    = r_res_prog;
  assign result_cycles  = r_res_cycles;
  assign result_timeout = r_res_timeout;
  assign result_error   = r_res_error;

endmodule

// File: tb/tb_core_run_sequencer.sv
// Directed bench for core_run_sequencer: vector table of jobs plus hand-written
// backpressure, timeout, stale-ack and mid-run reset sequences.
module tb_core_run_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        job_valid = 1'b0;
  logic [1:0]  job_prog = 2'd0;
  logic        ack = 1'b0;
  logic        result_ready = 1'b0;
  logic        job_ready, req, busy, result_valid, result_timeout, result_error;
  logic [8:0]  start_addr, done_addr;
  logic [1:0]  result_prog;
  logic [15:0] result_cycles;

  logic        t_job_valid = 1'b0;
  logic [1:0]  t_job_prog = 2'd0;
  logic        t_ack = 1'b0;
  logic        t_result_ready = 1'b0;
  logic        t_job_ready, t_req, t_busy, t_result_valid, t_result_timeout, t_result_error;
  logic [8:0]  t_start_addr, t_done_addr;
  logic [1:0]  t_result_prog;
  logic [15:0] t_result_cycles;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  core_run_sequencer dut (
    .clock(clock), .reset_n(reset_n), .job_valid(job_valid), .job_ready(job_ready),
    .job_prog(job_prog), .req(req), .ack(ack), .start_addr(start_addr),
    .done_addr(done_addr), .busy(busy), .result_valid(result_valid),
    .result_ready(result_ready), .result_prog(result_prog),
    .result_cycles(result_cycles), .result_timeout(result_timeout),
    .result_error(result_error)
  );

  core_run_sequencer #(.TIMEOUT(16'd20)) dut_to (
    .clock(clock), .reset_n(reset_n), .job_valid(t_job_valid), .job_ready(t_job_ready),
    .job_prog(t_job_prog), .req(t_req), .ack(t_ack), .start_addr(t_start_addr),
    .done_addr(t_done_addr), .busy(t_busy), .result_valid(t_result_valid),
    .result_ready(t_result_ready), .result_prog(t_result_prog),
    .result_cycles(t_result_cycles), .result_timeout(t_result_timeout),
    .result_error(t_result_error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  prog;
    int          ack_at;     // RUN cycle on which ack is high (0 = illegal job)
    logic        stale;      // ack already high when the job is offered
    logic [15:0] exp_cycles;
    logic        exp_error;
    logic [8:0]  exp_start;
    logic [8:0]  exp_done;
  } vec_t;

  vec_t vecs[6];

  task automatic run_job(input vec_t v, input int idx);
    int k;
    logic seen;
    string tag;
    tag = $sformatf("v%0d", idx);
    chk({tag, ".job_ready_idle"}, 32'(job_ready), 1);
    job_valid = 1'b1;
    job_prog  = v.prog;
    ack       = v.stale;
    @(negedge clock);
    job_valid = 1'b0;
    if (v.exp_error) begin
      chk({tag, ".valid_next"}, 32'(result_valid), 1);
      chk({tag, ".no_req"}, 32'(req), 0);
      chk({tag, ".cycles0"}, 32'(result_cycles), 0);
    end else begin
      chk({tag, ".req_launch"}, 32'(req), 1);
      chk({tag, ".busy"}, 32'(busy), 1);
      chk({tag, ".job_ready0"}, 32'(job_ready), 0);
      chk({tag, ".start"}, 32'(start_addr), 32'(v.exp_start));
      chk({tag, ".done"}, 32'(done_addr), 32'(v.exp_done));
      @(negedge clock);
      chk({tag, ".req_low"}, 32'(req), 0);
      seen = 1'b0;
      k = 0;
      for (int c = 1; c <= 100 && !seen; c++) begin
        ack = (c == v.ack_at) || (v.stale && c < v.ack_at);
        @(negedge clock);
        if (result_valid) begin seen = 1'b1; k = c; end
      end
      ack = 1'b0;
      chk({tag, ".result_seen"}, 32'(seen), 1);
      chk({tag, ".valid_edge"}, 32'(k), 32'(v.exp_cycles));
      chk({tag, ".start_hold"}, 32'(start_addr), 32'(v.exp_start));
    end
    chk({tag, ".cycles"}, 32'(result_cycles), 32'(v.exp_cycles));
    chk({tag, ".prog"}, 32'(result_prog), 32'(v.prog));
    chk({tag, ".timeout"}, 32'(result_timeout), 0);
    chk({tag, ".error"}, 32'(result_error), 32'(v.exp_error));
    result_ready = 1'b1;
    ack = 1'b0;
    @(negedge clock);
    result_ready = 1'b0;
    chk({tag, ".idle_after"}, 32'(job_ready), 1);
    chk({tag, ".valid_drop"}, 32'(result_valid), 0);
  endtask

  initial begin
    int k;
    logic seen;
    vecs[0] = '{prog: 2'd1, ack_at: 37, stale: 1'b0, exp_cycles: 16'd37, exp_error: 1'b0, exp_start: 9'd145, exp_done: 9'd289};
    vecs[1] = '{prog: 2'd0, ack_at: 1,  stale: 1'b0, exp_cycles: 16'd1,  exp_error: 1'b0, exp_start: 9'd0,   exp_done: 9'd144};
    vecs[2] = '{prog: 2'd2, ack_at: 5,  stale: 1'b0, exp_cycles: 16'd5,  exp_error: 1'b0, exp_start: 9'd290, exp_done: 9'd435};
    vecs[3] = '{prog: 2'd3, ack_at: 0,  stale: 1'b1, exp_cycles: 16'd0,  exp_error: 1'b1, exp_start: 9'd0,   exp_done: 9'd0};
    vecs[4] = '{prog: 2'd0, ack_at: 1,  stale: 1'b1, exp_cycles: 16'd1,  exp_error: 1'b0, exp_start: 9'd0,   exp_done: 9'd144};
    vecs[5] = '{prog: 2'd2, ack_at: 12, stale: 1'b0, exp_cycles: 16'd12, exp_error: 1'b0, exp_start: 9'd290, exp_done: 9'd435};

    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst.job_ready", 32'(job_ready), 1);
    chk("rst.req", 32'(req), 0);
    chk("rst.result_valid", 32'(result_valid), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.start_addr", 32'(start_addr), 0);
    chk("rst.cycles", 32'(result_cycles), 0);

    for (int i = 0; i < 6; i++) run_job(vecs[i], i);

    // Backpressure: prog 2, ack on RUN cycle 3, consumer stalls 10 cycles.
    job_valid = 1'b1; job_prog = 2'd2;
    @(negedge clock);
    job_valid = 1'b0;
    @(negedge clock);
    seen = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      ack = (c == 3);
      @(negedge clock);
      if (result_valid) seen = 1'b1;
    end
    ack = 1'b0;
    chk("bp.result_seen", 32'(seen), 1);
    for (int c = 0; c < 10; c++) begin
      job_valid = c[0];
      job_prog  = 2'd1;
      @(negedge clock);
      chk("bp.valid_hold", 32'(result_valid), 1);
      chk("bp.cycles_hold", 32'(result_cycles), 3);
      chk("bp.prog_hold", 32'(result_prog), 2);
      chk("bp.job_ready0", 32'(job_ready), 0);
    end
    job_valid = 1'b0;
    result_ready = 1'b1;
    @(negedge clock);
    result_ready = 1'b0;
    chk("bp.idle", 32'(job_ready), 1);
    chk("bp.busy0", 32'(busy), 0);
    chk("bp.no_accept", 32'(start_addr), 290);

    // Timeout on the TIMEOUT=20 instance with ack never asserted.
    t_job_valid = 1'b1; t_job_prog = 2'd1;
    @(negedge clock);
    t_job_valid = 1'b0;
    chk("to.req", 32'(t_req), 1);
    @(negedge clock);
    k = 0;
    for (int c = 1; c <= 40 && k == 0; c++) begin
      @(negedge clock);
      if (t_result_valid) k = c;
    end
    chk("to.valid_edge", 32'(k), 20);
    chk("to.timeout", 32'(t_result_timeout), 1);
    chk("to.cycles", 32'(t_result_cycles), 20);
    chk("to.error", 32'(t_result_error), 0);
    chk("to.prog", 32'(t_result_prog), 1);
    t_result_ready = 1'b1;
    @(negedge clock);
    t_result_ready = 1'b0;
    chk("to.idle", 32'(t_job_ready), 1);

    // Mid-run reset during RUN cycle 5.
    job_valid = 1'b1; job_prog = 2'd1;
    @(negedge clock);
    job_valid = 1'b0;
    repeat (5) @(negedge clock);
    chk("mr.busy_before", 32'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mr.req", 32'(req), 0);
    chk("mr.busy", 32'(busy), 0);
    chk("mr.job_ready", 32'(job_ready), 1);
    chk("mr.start_addr", 32'(start_addr), 0);
    @(negedge clock);
    reset_n = 1'b1;
    ack = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (result_valid || busy) seen = 1'b1;
    end
    ack = 1'b0;
    chk("mr.no_result", 32'(seen), 0);
    chk("mr.cycles", 32'(result_cycles), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
